logic_scan_feeder: RTL and testbench
====================================

# logic_scan_feeder

Upstream feeder for the parameterised AND/OR reduction array (`and_or_array`). It holds a small synchronous RAM of `WIDTH`-bit words and, on `start`, streams words `0..scan_len-1` one per cycle onto the array input `a_out`. It samples the array's reduced output `y_in` back into a per-word result vector. It also optionally counts how many words reduced to 1.

## Interface
- `WIDTH`, default 8: word width; equals the reduction array's `width`.
- `DEPTH`, default 16: number of RAM words.
- `AW`, default 4: address width; `DEPTH == 2**AW`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  RAM write strobe.
- `wr_addr`  in  AW  RAM write address.
- `wr_data`  in  WIDTH  RAM write data.
- `start`  in  1  single-cycle scan request.
- `scan_len`  in  AW+1  number of words to scan, 0..DEPTH; values above DEPTH saturate to DEPTH.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse when the scan completes.
- `a_out`  out  WIDTH  registered word driven into the reduction array.
- `a_valid`  out  1  `a_out` holds a word being scanned.
- `y_in`  in  1  reduction-array output; combinational function of `a_out`.
- `result`  out  DEPTH  bit i = sampled `y_in` for word i.
- `hit_count`  out  AW+1  number of 1s captured in `result` (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is in the shared package.
- Reset: all outputs and state clear.
  - FSM goes to IDLE.
  - `busy`, `done`, `a_valid` = 0; `a_out` = 0; `result` = 0; `hit_count` = 0.
  - RAM contents are not reset.
- IDLE:
  - `wr_en` writes `mem[wr_addr] <= wr_data`.
  - `start` with `scan_len != 0`: clear `result` and `hit_count`, load `len`, set `rd_idx = 0`, `cap_idx = 0`, go to RUN.
  - `start` with `scan_len == 0`: clear `result` and `hit_count`, go directly to DONE.
- RUN, each edge:
  - If `rd_idx < len`: `a_out <= mem[rd_idx]`, `a_valid <= 1`, `rd_idx++`.
  - Otherwise `a_valid <= 0`.
  - If `a_valid` was 1: `result[cap_idx] <= y_in`, `hit_count += y_in`, `cap_idx++`.
  - When `cap_idx` reaches `len` on this edge, go to DONE.
- DONE: lasts one cycle with `done = 1`, then returns to IDLE. `result` and `hit_count` hold until the next `start` or reset.
- `wr_en` while not in IDLE is ignored; the RAM is unchanged. `start` while not in IDLE is ignored.
- `start` and `wr_en` in the same IDLE cycle: the write lands, but the scan reads the pre-write contents only if the address has already been read. Since the read of word 0 happens one edge later, a same-cycle write to word 0 is visible to the scan.
- `a_out` holds its last scanned word after the scan; it is not cleared.
- Reset asserted during RUN or DONE: immediate return to reset values. No `done` is generated.

## Timing
- Let E0 be the edge that samples `start`.
- `busy` = 1 from E0 until the edge entering DONE.
- Word k (k = 0..len-1) appears on `a_out` after edge E(k+1) and is captured on edge E(k+2).
- `done` is high in the cycle after E(len+1), i.e. len+1 cycles after `start`. With `scan_len == 0`, `done` is high in the cycle after E0.
- Throughput: one word per cycle; there are no bubbles within a scan.
- Back-to-back: the earliest accepted `start` is in the cycle following the `done` cycle.

## Configuration
- `LOGIC_SCAN_COUNT_EN` defined: the `hit_count` accumulator is built; it is updated on every capture and cleared on start and reset.
- `LOGIC_SCAN_COUNT_EN` undefined: the accumulator is removed and `hit_count` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `logic_scan_pkg` holds:
  - FSM state encoding `S_IDLE`, `S_RUN`, `S_DONE`.
  - Default `WIDTH` / `DEPTH` / `AW` constants.
  - Saturation helper for `scan_len`.
- One sub-module, `scan_word_ram`:
  - single write port, synchronous registered read.
  - The read register is `a_out`.
- The FSM, index counters and result capture live in the top.

## Test plan
All scenarios use WIDTH=8, DEPTH=16, array in AND mode.
- Reset mid-scan: load 16 words, start with `scan_len = 16`, assert `rst` after 5 cycles → all outputs 0 on the next sample, no `done`; a new scan after release runs normally.
- Basic AND scan: write 0xFF, 0x7F, 0xFF, 0x00 to addresses 0–3, start with `scan_len = 4`.
  - `a_out` sequence 0xFF, 0x7F, 0xFF, 0x00 on consecutive cycles.
  - `done` 5 cycles after `start`; `result = 0x0005`; `hit_count = 2` (0 with the macro off).
- Full depth: all 16 words 0xFF, `scan_len = 16` → `result = 0xFFFF`, `hit_count = 16`, `done` 17 cycles after `start`.
- Zero and saturated length:
  - `scan_len = 0` → `done` one cycle after `start`, `result = 0`, `a_valid` never high.
  - `scan_len = 31` → behaves as 16.
- Lockout: during RUN, pulse `wr_en` to address 2 with 0x00 and pulse `start` → RAM word 2 unchanged and the scan is not restarted; a rescan gives the identical `result`.
- Same-cycle write and start: in IDLE, write 0x00 to address 0 together with `start` and `scan_len = 1` → `a_out = 0x00`, `result[0] = 0`.

Source files
------------

// File: rtl/logic_scan_feeder_pkg.sv
// Shared definitions for the logic_scan_feeder slice: FSM encoding, default
// geometry and the scan-length saturation helper.
package logic_scan_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 16;
    localparam int AW_DEF    = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } scan_state_e;

    // Requested lengths above the RAM depth are clamped to the full RAM.
    function automatic int unsigned sat_len(input int unsigned req, input int unsigned depth);
        return (req > depth) ? depth : req;
    endfunction

endpackage

// File: rtl/logic_scan_feeder_if.sv
// Bus bundle between the scan feeder (slave side) and whoever loads the RAM,
// requests scans and closes the loop through the reduction array (master side).
interface logic_scan_feeder_if
    import logic_scan_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) ();

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic [AW:0]      scan_len;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] a_out;
    logic             a_valid;
    logic             y_in;
    logic [DEPTH-1:0] result;
    logic [AW:0]      hit_count;

    modport master (
        output wr_en, wr_addr, wr_data, start, scan_len, y_in,
        input  busy, done, a_out, a_valid, result, hit_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, scan_len, y_in,
        output busy, done, a_out, a_valid, result, hit_count
    );

endinterface

// File: rtl/logic_scan_feeder_ram.sv
// Word store for the scan feeder: one write port and a registered read port
// whose output register is the word presented to the reduction array.
module scan_word_ram
    import logic_scan_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // NOTE: the array has no reset; clearing it would turn RAM into a flop bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register holds its word when no read is requested.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/logic_scan_feeder.sv
// Scan feeder: streams RAM words into the AND/OR reduction array and captures
// its reduced output per word. Define LOGIC_SCAN_COUNT_EN to build hit_count.
module logic_scan_feeder
    import logic_scan_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    logic_scan_feeder_if.slave  bus
);

    localparam int LW = AW + 1;

    scan_state_e      state_q, state_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    rd_idx_q, rd_idx_d;
    logic [LW-1:0]    cap_idx_q, cap_idx_d;
    logic             a_valid_q, a_valid_d;
    logic [DEPTH-1:0] result_q, result_d;
    logic [LW-1:0]    req_len;
    logic             rd_en;
    logic             wr_ok;
    logic             hit_clr;
    logic             hit_inc;

    assign req_len = LW'(sat_len(32'(bus.scan_len), DEPTH));

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rd_idx_d  = rd_idx_q;
        cap_idx_d = cap_idx_q;
        a_valid_d = a_valid_q;
        result_d  = result_q;
        rd_en     = 1'b0;
        wr_ok     = 1'b0;
        hit_clr   = 1'b0;
        hit_inc   = 1'b0;

        case (state_q)
            S_IDLE: begin
                wr_ok = 1'b1;
                if (bus.start) begin
                    result_d = '0;
                    hit_clr  = 1'b1;
                    if (req_len != '0) begin
                        len_d     = req_len;
                        rd_idx_d  = '0;
                        cap_idx_d = '0;
                        state_d   = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_RUN: begin
                if (rd_idx_q < len_q) begin
                    rd_en     = 1'b1;
                    a_valid_d = 1'b1;
                    rd_idx_d  = rd_idx_q + LW'(1);
                end else begin
                    a_valid_d = 1'b0;
                end
                // Capture trails the read by one edge: y_in reflects last cycle's word.
                if (a_valid_q) begin
                    result_d[cap_idx_q[AW-1:0]] = bus.y_in;
                    hit_inc   = bus.y_in;
                    cap_idx_d = cap_idx_q + LW'(1);
                    if (cap_idx_q + LW'(1) == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                a_valid_d = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                a_valid_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            rd_idx_q  <= '0;
            cap_idx_q <= '0;
            a_valid_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rd_idx_q  <= rd_idx_d;
            cap_idx_q <= cap_idx_d;
            a_valid_q <= a_valid_d;
            result_q  <= result_d;
        end
    end

`ifdef LOGIC_SCAN_COUNT_EN
    logic [LW-1:0] hit_count_q, hit_count_d;

    always_comb begin
        hit_count_d = hit_count_q;
        if (hit_clr) begin
            hit_count_d = '0;
        end else if (hit_inc) begin
            hit_count_d = hit_count_q + LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q <= '0;
        end else begin
            hit_count_q <= hit_count_d;
        end
    end

    assign bus.hit_count = hit_count_q;
`else
    logic unused_hit;
    assign unused_hit    = hit_clr ^ hit_inc;
    assign bus.hit_count = '0;
`endif

    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.a_valid = a_valid_q;
    assign bus.result  = result_q;

    // Writes are only honoured while idle so a running scan sees a stable RAM.
    scan_word_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en & wr_ok),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_idx_q[AW-1:0]),
        .rd_data (bus.a_out)
    );

endmodule

// File: tb/tb_logic_scan_feeder.sv
// Directed bench for logic_scan_feeder with the reduction array modelled in AND
// mode; scanned words are scoreboarded and the result vector rebuilt from a RAM model.
module tb_logic_scan_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_mem [16];
    logic [7:0] exp_q [$];

    logic_scan_feeder_if #(.WIDTH(8), .DEPTH(16), .AW(4)) bus ();

    // Reduction array in AND mode: purely combinational from a_out.
    assign bus.y_in = &bus.a_out;

    logic_scan_feeder #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int hit_exp(input int h);
`ifdef LOGIC_SCAN_COUNT_EN
        return h;
`else
        return 0 * h;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    32'(bus.busy),      32'd0);
        check({tag, "_done"},    32'(bus.done),      32'd0);
        check({tag, "_a_valid"}, 32'(bus.a_valid),   32'd0);
        check({tag, "_a_out"},   32'(bus.a_out),     32'd0);
        check({tag, "_result"},  32'(bus.result),    32'd0);
        check({tag, "_hits"},    32'(bus.hit_count), 32'd0);
    endtask

    // Called on a falling edge; the write is sampled on the next rising edge.
    task automatic wr(input logic [3:0] addr, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        model_mem[addr] = data;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // k counts sample points: k = n is the cycle after edge E(n) where E0 samples start.
    task automatic run_scan(input string tag, input logic [4:0] len,
                            input bit same_wr, input logic [3:0] wa, input logic [7:0] wd,
                            input bit poke);
        int eff;
        int k;
        int exp_hits;
        int done_k;
        bit seen_done;
        logic [15:0] exp_res;
        logic [7:0]  last_word;
        logic [7:0]  got;

        if (same_wr) model_mem[wa] = wd;
        eff       = (len > 5'd16) ? 16 : int'(len);
        done_k    = (eff == 0) ? 0 : eff + 1;
        exp_res   = '0;
        exp_hits  = 0;
        last_word = 8'h00;
        exp_q.delete();
        for (int i = 0; i < eff; i++) begin
            exp_q.push_back(model_mem[i]);
            exp_res[i] = &model_mem[i];
            exp_hits  += int'(exp_res[i]);
            last_word  = model_mem[i];
        end

        bus.start    = 1'b1;
        bus.scan_len = len;
        if (same_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = wa;
            bus.wr_data = wd;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;

        k = 0;
        seen_done = 1'b0;
        while (!seen_done && k < 40) begin
            check({tag, "_busy"},    32'(bus.busy),    32'((eff != 0) && (k <= eff)));
            check({tag, "_a_valid"}, 32'(bus.a_valid), 32'((k >= 1) && (k <= eff)));
            if (bus.a_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_word"}, 32'(bus.a_out), 32'hFFFF_FFFF);
                end else begin
                    got = exp_q.pop_front();
                    check({tag, "_a_out"}, 32'(bus.a_out), 32'(got));
                end
            end
            if (bus.done === 1'b1) begin
                seen_done = 1'b1;
                check({tag, "_done_cycle"}, 32'(k), 32'(done_k));
            end else begin
                if (poke && k == 2) begin
                    bus.wr_en    = 1'b1;
                    bus.wr_addr  = 4'd2;
                    bus.wr_data  = 8'h00;
                    bus.start    = 1'b1;
                    bus.scan_len = 5'd1;
                end else if (poke && k == 3) begin
                    bus.wr_en = 1'b0;
                    bus.start = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        if (!seen_done) check({tag, "_done_timeout"}, 32'd0, 32'd1);

        check({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_result"},     32'(bus.result),    32'(exp_res));
        check({tag, "_hits"},       32'(bus.hit_count), 32'(hit_exp(exp_hits)));
        if (eff != 0) check({tag, "_a_out_hold"}, 32'(bus.a_out), 32'(last_word));

        // Leave DONE; the next start lands in IDLE.
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.start    = 1'b0;
        bus.scan_len = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Reset during RUN: everything clears at once and no done appears.
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), (i % 2 == 1) ? 8'hFF : 8'(8'h80 + i));
        end
        bus.start    = 1'b1;
        bus.scan_len = 5'd16;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrst_no_done", 32'(bus.done), 32'd0);
            check("midrst_no_busy", 32'(bus.busy), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        run_scan("post_rst", 5'd16, 1'b0, 4'd0, 8'h00, 1'b0);

        // Basic AND scan.
        wr(4'd0, 8'hFF);
        wr(4'd1, 8'h7F);
        wr(4'd2, 8'hFF);
        wr(4'd3, 8'h00);
        run_scan("basic", 5'd4, 1'b0, 4'd0, 8'h00, 1'b0);
        check("basic_result_const", 32'(bus.result), 32'h0000_0005);

        // Full depth, all ones.
        for (int i = 0; i < 16; i++) wr(4'(i), 8'hFF);
        run_scan("full", 5'd16, 1'b0, 4'd0, 8'h00, 1'b0);
        check("full_result_const", 32'(bus.result), 32'h0000_FFFF);

        // Zero length clears the previous result without streaming anything.
        run_scan("zero", 5'd0, 1'b0, 4'd0, 8'h00, 1'b0);

        // Oversized length saturates to the full RAM.
        wr(4'd5, 8'hFE);
        wr(4'd15, 8'hFE);
        run_scan("sat", 5'd31, 1'b0, 4'd0, 8'h00, 1'b0);
        check("sat_result_const", 32'(bus.result), 32'h0000_7FDF);

        // Write and start during RUN are both ignored; a rescan repeats the result.
        run_scan("lock", 5'd8, 1'b0, 4'd0, 8'h00, 1'b1);
        run_scan("lock_rescan", 5'd8, 1'b0, 4'd0, 8'h00, 1'b0);
        check("lock_result_const", 32'(bus.result), 32'h0000_00DF);

        // A write in the start cycle to word 0 is seen by the scan.
        run_scan("same_cycle", 5'd1, 1'b1, 4'd0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
